// File: rtl/latex_uart_pkg.sv
// rtl/latex_uart_pkg.sv - shared types and constants for latex_uart_tx (UART_PARITY_EN adds ST_PARITY)
package latex_uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_EOL_CR,
        ST_EOL_LF
    } tx_state_t;

    // Which byte the current frame carries; decides where STOP goes next.
    typedef enum logic [1:0] {
        KIND_DATA,
        KIND_CR,
        KIND_LF
    } frame_kind_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/latex_uart_tx_char_fifo.sv
// rtl/latex_uart_tx_char_fifo.sv - 9-bit synchronous FIFO with occupancy output
module char_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   rd_en,
    output logic [8:0]             rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign wr_ready = (level != LW'(DEPTH));
    assign empty    = (level == '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_en && !empty;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/latex_uart_tx.sv
// rtl/latex_uart_tx.sv - FIFO-buffered 8N1 UART transmitter with automatic CR LF; UART_PARITY_EN adds even parity
module latex_uart_tx
    import latex_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_char,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);
    tx_state_t   state;
    tx_state_t   state_next;
    frame_kind_t kind;
    logic [15:0] baud_cnt;
    logic        baud_done;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        eol_flag;
    logic [8:0]  head_bits;
    fifo_entry_t head;
    logic        fifo_empty;
    logic        pop;

    char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  ({in_last, in_char}),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .rd_en    (pop),
        .rd_data  (head_bits),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign head      = fifo_entry_t'(head_bits);
    assign baud_done = (baud_cnt == 16'(CLKS_PER_BIT - 1));
    // A pending CR LF takes priority over the next queued character.
    assign pop       = (state == ST_IDLE) && !eol_flag && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (pop) state_next = ST_START;
            ST_START:  if (baud_done) state_next = ST_DATA;
`ifdef UART_PARITY_EN
            ST_DATA:   if (baud_done && bit_idx == 3'd7) state_next = ST_PARITY;
            ST_PARITY: if (baud_done) state_next = ST_STOP;
`else
            ST_DATA:   if (baud_done && bit_idx == 3'd7) state_next = ST_STOP;
`endif
            ST_STOP: begin
                if (baud_done) begin
                    if (kind == KIND_DATA && eol_flag) state_next = ST_EOL_CR;
                    else if (kind == KIND_CR)          state_next = ST_EOL_LF;
                    else                               state_next = ST_IDLE;
                end
            end
            ST_EOL_CR: state_next = ST_START;
            ST_EOL_LF: state_next = ST_START;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_reg[bit_idx];
`ifdef UART_PARITY_EN
            ST_PARITY: tx = ^shift_reg;
`endif
            default:   tx = 1'b1;
        endcase
        busy = (state != ST_IDLE) || (fifo_level != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            eol_flag  <= 1'b0;
            kind      <= KIND_DATA;
        end else begin
            if (state_next != state || baud_done) baud_cnt <= '0;
            else                                  baud_cnt <= baud_cnt + 16'd1;

            if (state != ST_DATA)  bit_idx <= '0;
            else if (baud_done)    bit_idx <= bit_idx + 3'd1;

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift_reg <= head.data;
                        eol_flag  <= head.last;
                        kind      <= KIND_DATA;
                    end
                end
                ST_EOL_CR: begin
                    shift_reg <= ASCII_CR;
                    kind      <= KIND_CR;
                end
                ST_EOL_LF: begin
                    shift_reg <= ASCII_LF;
                    kind      <= KIND_LF;
                    eol_flag  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
